// File: rtl/frac_mv_scheduler_pkg.sv
// frac_mv_pkg: shared widths, FSM states and the fractional-MV neighbour offset table
package frac_mv_pkg;
    localparam int MV_W_DEF = 19;
    localparam int COST_W_DEF = 16;
    localparam int STEP_DEF = 2;
    localparam logic [3:0] BEST_IDX_BASE = 4'd8;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_FINISH} state_t;
    // Neighbours in raster order around the base, centre excluded
    localparam logic signed [1:0] DX_TAB [8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam logic signed [1:0] DY_TAB [8] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
endpackage

// File: rtl/frac_mv_scheduler_if.sv
// frac_mv_scheduler_if: request, MV-generator and interpolation handshake bundle
interface frac_mv_scheduler_if
    import frac_mv_pkg::*;
#(
    parameter int MV_W = MV_W_DEF,
    parameter int COST_W = COST_W_DEF
);
    logic START;
    logic signed [MV_W-1:0] BASE_MV_X;
    logic signed [MV_W-1:0] BASE_MV_Y;
    logic [COST_W-1:0] BASE_COST;
    logic MV_WE;
    logic signed [MV_W-1:0] MV_X_OUT;
    logic signed [MV_W-1:0] MV_Y_OUT;
    logic INTERP_START;
    logic INTERP_DONE;
    logic [COST_W-1:0] INTERP_COST;
    logic BUSY;
    logic DONE;
    logic signed [MV_W-1:0] BEST_MV_X;
    logic signed [MV_W-1:0] BEST_MV_Y;
    logic [COST_W-1:0] BEST_COST;
    logic [3:0] BEST_IDX;
    modport master (
        output START, BASE_MV_X, BASE_MV_Y, BASE_COST, INTERP_DONE, INTERP_COST,
        input MV_WE, MV_X_OUT, MV_Y_OUT, INTERP_START, BUSY, DONE,
        input BEST_MV_X, BEST_MV_Y, BEST_COST, BEST_IDX
    );
    modport slave (
        input START, BASE_MV_X, BASE_MV_Y, BASE_COST, INTERP_DONE, INTERP_COST,
        output MV_WE, MV_X_OUT, MV_Y_OUT, INTERP_START, BUSY, DONE,
        output BEST_MV_X, BEST_MV_Y, BEST_COST, BEST_IDX
    );
endinterface

// File: rtl/frac_mv_scheduler_mv_sat_add.sv
// mv_sat_add: signed MV component add, clamped to the MV_W range instead of wrapping
module mv_sat_add
    import frac_mv_pkg::*;
#(
    parameter int MV_W = MV_W_DEF
) (
    input  logic signed [MV_W-1:0] i_a,
    input  logic signed [MV_W-1:0] i_b,
    output logic signed [MV_W-1:0] o_sum
);
    logic [MV_W:0] w_sum;
    assign w_sum = {i_a[MV_W-1], i_a} + {i_b[MV_W-1], i_b};
    // Top two bits disagree only on overflow; the true sign picks the rail
    assign o_sum = (w_sum[MV_W] == w_sum[MV_W-1]) ? w_sum[MV_W-1:0]
                                                  : {w_sum[MV_W], {(MV_W-1){~w_sum[MV_W]}}};
endmodule

// File: rtl/frac_mv_scheduler.sv
// frac_mv_scheduler: walks 8 fractional neighbours of a base MV through interpolation and keeps the cheapest
module frac_mv_scheduler
    import frac_mv_pkg::*;
#(
    parameter int MV_W = MV_W_DEF,
    parameter int COST_W = COST_W_DEF,
    parameter int STEP = STEP_DEF
) (
    input logic CLK,
    input logic RST_ASYNC_N,
    frac_mv_scheduler_if.slave bus
);
    state_t r_state;
    logic [2:0] r_idx;
    logic signed [MV_W-1:0] r_base_x, r_base_y;
    logic r_mv_we, r_interp_start, r_busy, r_done;
    logic signed [MV_W-1:0] r_mv_x, r_mv_y, r_best_x, r_best_y;
    logic [COST_W-1:0] r_best_cost;
    logic [3:0] r_best_idx;
    logic [2:0] w_nidx;
    logic signed [MV_W-1:0] w_bx, w_by, w_ofs_x, w_ofs_y, w_cand_x, w_cand_y;
    // Candidate is formed for the entry into LOAD so MV_X/Y_OUT stay registered
    assign w_nidx = (r_state == S_IDLE) ? 3'd0 : r_idx + 3'd1;
    assign w_bx = (r_state == S_IDLE) ? bus.BASE_MV_X : r_base_x;
    assign w_by = (r_state == S_IDLE) ? bus.BASE_MV_Y : r_base_y;
    assign w_ofs_x = MV_W'(DX_TAB[w_nidx] * STEP);
    assign w_ofs_y = MV_W'(DY_TAB[w_nidx] * STEP);
    mv_sat_add #(.MV_W(MV_W)) u_add_x (.i_a(w_bx), .i_b(w_ofs_x), .o_sum(w_cand_x));
    mv_sat_add #(.MV_W(MV_W)) u_add_y (.i_a(w_by), .i_b(w_ofs_y), .o_sum(w_cand_y));
    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            r_state <= S_IDLE;
            r_idx <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
            r_mv_we <= 1'b0;
            r_mv_x <= '0;
            r_mv_y <= '0;
            r_interp_start <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_best_x <= '0;
            r_best_y <= '0;
            r_best_cost <= '0;
            r_best_idx <= '0;
        end else begin
            r_mv_we <= 1'b0;
            r_interp_start <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.START) begin
                    r_base_x <= bus.BASE_MV_X;
                    r_base_y <= bus.BASE_MV_Y;
                    r_best_x <= bus.BASE_MV_X;
                    r_best_y <= bus.BASE_MV_Y;
                    r_best_cost <= bus.BASE_COST;
                    r_best_idx <= BEST_IDX_BASE;
                    r_idx <= w_nidx;
                    r_mv_we <= 1'b1;
                    r_mv_x <= w_cand_x;
                    r_mv_y <= w_cand_y;
                    r_busy <= 1'b1;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_interp_start <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: if (bus.INTERP_DONE) begin
                    // Strict compare keeps the earlier entry (or the base) on ties
                    if (bus.INTERP_COST < r_best_cost) begin
                        r_best_x <= r_mv_x;
                        r_best_y <= r_mv_y;
                        r_best_cost <= bus.INTERP_COST;
                        r_best_idx <= {1'b0, r_idx};
                    end
                    if (r_idx == 3'd7) begin
                        r_done <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_idx <= w_nidx;
                        r_mv_we <= 1'b1;
                        r_mv_x <= w_cand_x;
                        r_mv_y <= w_cand_y;
                        r_state <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    r_busy <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
    assign bus.MV_WE = r_mv_we;
    assign bus.MV_X_OUT = r_mv_x;
    assign bus.MV_Y_OUT = r_mv_y;
    assign bus.INTERP_START = r_interp_start;
    assign bus.BUSY = r_busy;
    assign bus.DONE = r_done;
    assign bus.BEST_MV_X = r_best_x;
    assign bus.BEST_MV_Y = r_best_y;
    assign bus.BEST_COST = r_best_cost;
    assign bus.BEST_IDX = r_best_idx;
endmodule

// File: tb/tb_frac_mv_scheduler.sv
// tb_frac_mv_scheduler: randomized runs checked against a 3x3-grid arithmetic reference model
module tb_frac_mv_scheduler;
    localparam int MV_W = 19;
    localparam int COST_W = 16;
    localparam int STEP = 2;
    localparam longint MAXV = (longint'(1) << (MV_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (MV_W - 1));
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int costs[8];
    int dly[8];

    frac_mv_scheduler_if #(.MV_W(MV_W), .COST_W(COST_W)) bus ();
    frac_mv_scheduler #(.MV_W(MV_W), .COST_W(COST_W), .STEP(STEP)) dut (
        .CLK(clk), .RST_ASYNC_N(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return v > MAXV ? MAXV : (v < MINV ? MINV : v);
    endfunction

    // Candidate i is the i-th cell of the 3x3 raster with the centre skipped
    function automatic int ofs_dx(input int i);
        int p = i < 4 ? i : i + 1;
        return p % 3 - 1;
    endfunction

    function automatic int ofs_dy(input int i);
        int p = i < 4 ? i : i + 1;
        return p / 3 - 1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, bus.MV_WE, 0);
        chk({tag, "_istart"}, bus.INTERP_START, 0);
        chk({tag, "_busy"}, bus.BUSY, 0);
        chk({tag, "_done"}, bus.DONE, 0);
        chk({tag, "_mvx"}, longint'(bus.MV_X_OUT), 0);
        chk({tag, "_mvy"}, longint'(bus.MV_Y_OUT), 0);
        chk({tag, "_bx"}, longint'(bus.BEST_MV_X), 0);
        chk({tag, "_by"}, longint'(bus.BEST_MV_Y), 0);
        chk({tag, "_bcost"}, bus.BEST_COST, 0);
        chk({tag, "_bidx"}, bus.BEST_IDX, 0);
    endtask

    task automatic run(input longint bx, input longint by, input int bcost,
                       input bit inject, input int rst_k, input int exp_cyc);
        longint ex[8], ey[8];
        longint best_x = bx, best_y = by;
        int best_c = bcost, best_i = 8;
        int k = 0, nwe = 0, pend = 0, cyc = 0, viol = 0, done_cyc = -1, late_done = 0;
        bit aborted = 0;
        for (int i = 0; i < 8; i++) begin
            ex[i] = sat(bx + ofs_dx(i) * STEP);
            ey[i] = sat(by + ofs_dy(i) * STEP);
            if (costs[i] < best_c) begin
                best_x = ex[i];
                best_y = ey[i];
                best_c = costs[i];
                best_i = i;
            end
        end
        if (inject) begin
            @(negedge clk);
            bus.INTERP_DONE = 1'b1;
            bus.INTERP_COST = '0;
            @(negedge clk);
            bus.INTERP_DONE = 1'b0;
        end
        @(negedge clk);
        bus.START = 1'b1;
        bus.BASE_MV_X = MV_W'(bx);
        bus.BASE_MV_Y = MV_W'(by);
        bus.BASE_COST = COST_W'(bcost);
        @(negedge clk);
        bus.START = 1'b0;
        bus.BASE_MV_X = MV_W'($urandom);
        bus.BASE_MV_Y = MV_W'($urandom);
        bus.BASE_COST = COST_W'($urandom);
        cyc = 1;
        while (done_cyc < 0 && !aborted && cyc < LIMIT) begin
            bus.INTERP_DONE = 1'b0;
            bus.START = 1'b0;
            if (bus.MV_WE && bus.INTERP_START) viol++;
            if (cyc == 1) chk("busy_in_run", bus.BUSY, 1);
            if (bus.MV_WE) begin
                if (nwe < 8) begin
                    chk($sformatf("cand%0d_x", nwe), longint'(bus.MV_X_OUT), ex[nwe]);
                    chk($sformatf("cand%0d_y", nwe), longint'(bus.MV_Y_OUT), ey[nwe]);
                end
                nwe++;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.INTERP_DONE = 1'b1;
                    bus.INTERP_COST = COST_W'(costs[k]);
                    k++;
                end else if (inject && k == 2) begin
                    bus.START = 1'b1;
                end else if (rst_k == k) begin
                    rst_n = 1'b0;
                    #1;
                    chk_zero("async_rst");
                    aborted = 1;
                end
            end
            if (bus.INTERP_START && !aborted) begin
                pend = dly[k < 8 ? k : 7] + 1;
                if (inject) begin
                    bus.INTERP_DONE = 1'b1;
                    bus.INTERP_COST = '0;
                end
            end
            if (bus.DONE) done_cyc = cyc;
            if (!aborted) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.INTERP_DONE = 1'b0;
        bus.START = 1'b0;
        if (aborted) begin
            repeat (2) @(negedge clk);
            chk("rst_held_busy", bus.BUSY, 0);
            rst_n = 1'b1;
            repeat (6) begin
                @(negedge clk);
                late_done += int'(bus.DONE) + int'(bus.BUSY);
            end
            chk("no_done_after_rst", late_done, 0);
        end else begin
            chk("done_seen", done_cyc >= 0, 1);
            chk("cand_count", nwe, 8);
            chk("costs_used", k, 8);
            chk("we_start_excl", viol, 0);
            if (exp_cyc > 0) chk("latency", done_cyc, exp_cyc);
            chk("best_x", longint'(bus.BEST_MV_X), best_x);
            chk("best_y", longint'(bus.BEST_MV_Y), best_y);
            chk("best_cost", bus.BEST_COST, best_c);
            chk("best_idx", bus.BEST_IDX, best_i);
            @(negedge clk);
            chk("done_pulse", bus.DONE, 0);
            chk("busy_after", bus.BUSY, 0);
            chk("best_hold", bus.BEST_IDX, best_i);
        end
    endtask

    task automatic rand_costs(input int lo, input int hi, input int dmax);
        for (int i = 0; i < 8; i++) begin
            costs[i] = int'($urandom_range(hi, lo));
            dly[i] = int'($urandom_range(dmax, 0));
        end
    endtask

    initial begin
        bus.START = 1'b0;
        bus.BASE_MV_X = '0;
        bus.BASE_MV_Y = '0;
        bus.BASE_COST = '0;
        bus.INTERP_DONE = 1'b0;
        bus.INTERP_COST = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        costs = '{50, 40, 60, 40, 70, 80, 90, 99};
        dly = '{1, 0, 2, 3, 0, 1, 4, 2};
        run(100, -40, 45, 0, -1, 0);
        costs = '{30, 30, 30, 30, 30, 30, 30, 30};
        run(-7, 13, 30, 0, -1, 0);
        rand_costs(10, 60, 3);
        run(MAXV, MINV, 1000, 0, -1, 0);
        rand_costs(10, 60, 3);
        run(MINV + 1, MAXV - 1, 35, 0, -1, 0);
        rand_costs(10, 60, 3);
        dly[2] = 3;
        run(5, 6, 40, 1, -1, 0);
        rand_costs(10, 60, 3);
        dly[4] = 3;
        run(-300, 200, 40, 0, 4, 0);
        rand_costs(10, 60, 3);
        run(17, -17, 45, 0, -1, 0);
        rand_costs(10, 60, 0);
        dly = '{0, 0, 0, 0, 0, 0, 0, 0};
        run(1, 2, 40, 0, -1, 25);
        rand_costs(10, 60, 0);
        dly = '{20, 20, 20, 20, 20, 20, 20, 20};
        run(-1, -2, 40, 0, -1, 185);
        for (int r = 0; r < 6; r++) begin
            longint bx, by;
            bx = ($urandom_range(2, 0) == 0) ? MAXV - $urandom_range(3, 0) : longint'($signed(MV_W'($urandom)));
            by = ($urandom_range(2, 0) == 0) ? MINV + $urandom_range(3, 0) : longint'($signed(MV_W'($urandom)));
            rand_costs(20, 40, 4);
            run(bx, by, int'($urandom_range(40, 20)), 0, -1, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
